time_keeper_display: RTL



---
 rtl/time_display_pkg.sv | 65 ++++++
 rtl/seven_seg_encode.sv | 23 ++
 rtl/time_keeper_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/time_display_pkg.sv
// Shared definitions for the time keeper and its seven-segment display path.
// Contents:
//   SEC_MAX / MIN_MAX / HOUR_MAX : wrap points of the time fields
//   NUM_DIGITS                   : number of multiplexed display digits
//   BLANK                        : all-segments-off pattern (active-high)
//   bcd_t, to_bcd()              : tens/units split of a 0..59 value
//   seg_encode()                 : digit 0..9 -> active-high {dp,g,f,e,d,c,b,a}
package time_display_pkg;

   localparam logic [5:0] SEC_MAX    = 6'd59;
   localparam logic [5:0] MIN_MAX    = 6'd59;
   localparam logic [4:0] HOUR_MAX   = 5'd23;
   localparam int         NUM_DIGITS = 4;
   localparam logic [7:0] BLANK      = 8'h00;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_t;

   // Compare/subtract split; the input never exceeds 59, so no divider is needed.
   function automatic bcd_t to_bcd(input logic [5:0] value);
      bcd_t       r;
      logic [5:0] rem;
      r.tens = 4'd0;
      rem    = value;
      if (value >= 6'd50) begin
         r.tens = 4'd5;
         rem    = value - 6'd50;
      end else if (value >= 6'd40) begin
         r.tens = 4'd4;
         rem    = value - 6'd40;
      end else if (value >= 6'd30) begin
         r.tens = 4'd3;
         rem    = value - 6'd30;
      end else if (value >= 6'd20) begin
         r.tens = 4'd2;
         rem    = value - 6'd20;
      end else if (value >= 6'd10) begin
         r.tens = 4'd1;
         rem    = value - 6'd10;
      end
      r.units = rem[3:0];
      return r;
   endfunction

   function automatic logic [7:0] seg_encode(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = 8'h3F;
         4'd1:    seg = 8'h06;
         4'd2:    seg = 8'h5B;
         4'd3:    seg = 8'h4F;
         4'd4:    seg = 8'h66;
         4'd5:    seg = 8'h6D;
         4'd6:    seg = 8'h7D;
         4'd7:    seg = 8'h07;
         4'd8:    seg = 8'h7F;
         4'd9:    seg = 8'h6F;
         default: seg = BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_seg_encode.sv
// Combinational seven-segment encoder, active-high segments.
// Ports:
//   digit    in  4  value 0..9 to show
//   blank    in  1  1 = all segments a..g off
//   dp       in  1  decimal point / colon segment
//   segments out 8  {dp,g,f,e,d,c,b,a}
module seven_seg_encode
   import time_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] segments
);

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      segments    = blank ? BLANK : seg_encode(digit);
      segments[7] = dp;
   end

endmodule

// File: rtl/time_keeper_display.sv
// Hours/minutes/seconds time keeper with manual setting and a 4-digit
// multiplexed seven-segment display (HH:MM or MM:SS, optional 12-hour view,
// blinking colon on digit 2). Single clock; the second rate comes from a
// clock-enable prescaler, not a derived clock.
// Ports:
//   cmosClock          in   1  board clock, rising edge
//   reset              in   1  synchronous, active-high
//   runEnable          in   1  1 = time advances, 0 = prescaler and time frozen
//   setHour            in   1  one-cycle pulse: hour +1
//   setMinute          in   1  one-cycle pulse: minute +1, seconds cleared
//   displayMode        in   1  0 = HH:MM, 1 = MM:SS
//   format12           in   1  1 = 12-hour view (HH:MM only)
//   secondTick         out  1  one-cycle pulse with each seconds increment
//   hours              out  5  0..23
//   minutes            out  6  0..59
//   seconds            out  6  0..59
//   sevenSegmentEnable out  4  bit i selects digit i, d0 rightmost
//   sevenSegmentData   out  8  {dp,g,f,e,d,c,b,a}
module time_keeper_display
   import time_display_pkg::*;
#(
   parameter int TICKS_PER_SECOND = 100000000,
   parameter int REFRESH_DIV      = 100000,
   parameter int ACTIVE_LOW       = 1
) (
   input  logic                  cmosClock,
   input  logic                  reset,
   input  logic                  runEnable,
   input  logic                  setHour,
   input  logic                  setMinute,
   input  logic                  displayMode,
   input  logic                  format12,
   output logic                  secondTick,
   output logic [4:0]            hours,
   output logic [5:0]            minutes,
   output logic [5:0]            seconds,
   output logic [NUM_DIGITS-1:0] sevenSegmentEnable,
   output logic [7:0]            sevenSegmentData
);

   localparam int PRESC_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
   localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SECOND - 1);
   localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICKS_PER_SECOND / 2);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
   localparam logic [REF_W-1:0]   REF_ONE    = REF_W'(1);

   // XOR masks applied at the output registers; all ones for an active-low board.
   localparam logic                  INVERT   = (ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] EN_MASK  = {NUM_DIGITS{INVERT}};
   localparam logic [7:0]            SEG_MASK = {8{INVERT}};

   logic [PRESC_W-1:0] presc;
   logic [REF_W-1:0]   refresh_cnt;
   logic [1:0]         scan_idx;

   logic set_any;
   assign set_any = setHour | setMinute;

   // ---------------------------------------------------------------------------
   // Prescaler, time cascade and manual setting. A set pulse restarts the
   // second and swallows a tick that would land on the same edge.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, matching the flop hardware.
   always_ff @(posedge cmosClock) begin
      if (reset) begin
         presc      <= '0;
         secondTick <= 1'b0;
         hours      <= '0;
         minutes    <= '0;
         seconds    <= '0;
      end else if (set_any) begin
         presc      <= '0;
         secondTick <= 1'b0;
         if (setMinute) begin
            minutes <= (minutes == MIN_MAX) ? 6'd0 : minutes + 6'd1;
            seconds <= '0;
         end
         if (setHour) begin
            hours <= (hours == HOUR_MAX) ? 5'd0 : hours + 5'd1;
         end
      end else if (runEnable && (presc == PRESC_LAST)) begin
         presc      <= '0;
         secondTick <= 1'b1;
         if (seconds == SEC_MAX) begin
            seconds <= '0;
            if (minutes == MIN_MAX) begin
               minutes <= '0;
               hours   <= (hours == HOUR_MAX) ? 5'd0 : hours + 5'd1;
            end else begin
               minutes <= minutes + 6'd1;
            end
         end else begin
            seconds <= seconds + 6'd1;
         end
      end else begin
         secondTick <= 1'b0;
         if (runEnable) presc <= presc + PRESC_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit scan: each digit is held for REFRESH_DIV cycles.
   // ---------------------------------------------------------------------------
   always_ff @(posedge cmosClock) begin
      if (reset) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
      end else if (refresh_cnt == REF_LAST) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + REF_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit selection
   // ---------------------------------------------------------------------------
   logic [4:0] hour_disp;
   bcd_t       hour_bcd;
   bcd_t       min_bcd;
   bcd_t       sec_bcd;
   logic       colon_lit;
   logic [3:0] cur_digit;
   logic       cur_blank;
   logic       cur_dp;
   logic [7:0] seg_next;
   logic [NUM_DIGITS-1:0] enable_next;

   // 12-hour view: 0 and 12 both read as 12, 13..23 read as 1..11.
   always_comb begin
      hour_disp = hours;
      if (format12 && !displayMode) begin
         if (hours >= 5'd12) hour_disp = hours - 5'd12;
         if (hour_disp == 5'd0) hour_disp = 5'd12;
      end
   end

   assign hour_bcd  = to_bcd({1'b0, hour_disp});
   assign min_bcd   = to_bcd(minutes);
   assign sec_bcd   = to_bcd(seconds);
   // Steady when stopped, otherwise lit for the first half of each second.
   assign colon_lit = !runEnable || (presc < PRESC_HALF);

   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      case (scan_idx)
         2'd3: begin
            cur_digit = displayMode ? min_bcd.tens : hour_bcd.tens;
            // Leading-zero suppression only in the 12-hour clock view.
            cur_blank = !displayMode && format12 && (hour_bcd.tens == 4'd0);
         end
         2'd2: begin
            cur_digit = displayMode ? min_bcd.units : hour_bcd.units;
            cur_dp    = colon_lit;
         end
         2'd1:    cur_digit = displayMode ? sec_bcd.tens : min_bcd.tens;
         default: cur_digit = displayMode ? sec_bcd.units : min_bcd.units;
      endcase
   end

   assign enable_next = NUM_DIGITS'(1) << scan_idx;

   seven_seg_encode u_encode (
      .digit    (cur_digit),
      .blank    (cur_blank),
      .dp       (cur_dp),
      .segments (seg_next)
   );

   // Enable and data share one register stage so they never skew apart.
   always_ff @(posedge cmosClock) begin
      if (reset) begin
         sevenSegmentEnable <= EN_MASK;
         sevenSegmentData   <= SEG_MASK;
      end else begin
         sevenSegmentEnable <= enable_next ^ EN_MASK;
         sevenSegmentData   <= seg_next ^ SEG_MASK;
      end
   end

endmodule
